// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD/hex up/down counter with a time-multiplexed, active-low 7-segment driver.
// The tick and scan timers run freely; display outputs are registered one cycle behind the scan position.
module seg7_scan_counter #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000000,
  parameter int DIGIT_CYCLES = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic                    clock_100Mhz,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [4*NUM_DIGITS-1:0] count_value,
  output logic                    tick_out
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  logic [TICK_W-1:0]       tick_cnt;
  logic                    tick;
  logic [SCAN_W-1:0]       scan_cnt;
  logic                    scan_wrap;
  logic                    in_blank;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              digit_max;
  logic [4*NUM_DIGITS-1:0] step_value;
  logic [4*NUM_DIGITS-1:0] load_clamped;
  logic [3:0]              digit_sel;
  logic                    dp_sel;
  logic                    lz_sel;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic [6:0]              seg_next;

  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    // Out-of-range digits in decimal mode light only segment g as an error marker.
    if (!hex && nib > 4'h9) s = 7'b1111110;
    return s;
  endfunction

  assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign scan_wrap = (scan_cnt == SCAN_W'(DIGIT_CYCLES - 1));
  assign in_blank  = (BLANK_CYCLES != 0) && (scan_cnt < SCAN_W'(BLANK_CYCLES));
  assign digit_max = hex_mode ? 4'hF : 4'h9;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      tick_out <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      tick_out <= tick;
    end
  end

  always_comb begin
    logic       carry;
    logic [3:0] cur;
    step_value   = count_value;
    load_clamped = load_value;
    carry        = 1'b1;
    cur          = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur = count_value[4*i +: 4];
      if (carry) begin
        if (up_down) begin
          if (cur >= digit_max) begin
            step_value[4*i +: 4] = 4'h0;
          end else begin
            step_value[4*i +: 4] = cur + 4'h1;
            carry = 1'b0;
          end
        end else begin
          if (cur == 4'h0) begin
            step_value[4*i +: 4] = digit_max;
          end else begin
            step_value[4*i +: 4] = cur - 4'h1;
            carry = 1'b0;
          end
        end
      end
      if (!hex_mode && load_value[4*i +: 4] > 4'h9) load_clamped[4*i +: 4] = 4'h9;
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      count_value <= '0;
    end else if (load) begin
      count_value <= load_clamped;
    end else if (tick && en) begin
      count_value <= step_value;
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Walking from the top digit down, upper_zero means digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    digit_sel  = 4'h0;
    dp_sel     = 1'b0;
    lz_sel     = 1'b0;
    anode_next = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (count_value[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        digit_sel     = count_value[4*i +: 4];
        dp_sel        = dp_in[i];
        lz_sel        = upper_zero;
        anode_next[i] = 1'b0;
      end
    end
    seg_next = (blank_lz && idx != '0 && lz_sel) ? 7'b1111111 : decode(digit_sel, hex_mode);
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      anode <= '1;
      seg   <= '1;
      dp    <= 1'b1;
    end else if (in_blank) begin
      anode <= '1;
      seg   <= '1;
      dp    <= 1'b1;
    end else begin
      anode <= anode_next;
      seg   <= seg_next;
      dp    <= ~dp_sel;
    end
  end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Directed bench for seg7_scan_counter with small timers (tick every 10 cycles, 8-cycle slots, 2 blank).
// Outputs are sampled on the falling clock edge.
module tb_seg7_scan_counter;

  logic        clock_100Mhz = 1'b0;
  logic        reset        = 1'b1;
  logic        en           = 1'b0;
  logic        up_down      = 1'b1;
  logic        load         = 1'b0;
  logic [15:0] load_value   = 16'h0000;
  logic        hex_mode     = 1'b0;
  logic        blank_lz     = 1'b0;
  logic [3:0]  dp_in        = 4'b0000;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] count_value;
  logic        tick_out;

  int checks = 0;
  int errors = 0;

  seg7_scan_counter #(
    .NUM_DIGITS  (4),
    .TICK_DIV    (10),
    .DIGIT_CYCLES(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .en          (en),
    .up_down     (up_down),
    .load        (load),
    .load_value  (load_value),
    .hex_mode    (hex_mode),
    .blank_lz    (blank_lz),
    .dp_in       (dp_in),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .count_value (count_value),
    .tick_out    (tick_out)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clock_100Mhz);
    load       = 1'b1;
    load_value = v;
    @(negedge clock_100Mhz);
    load       = 1'b0;
  endtask

  // Returns on the falling edge right after a tick step; n is the number of cycles waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clock_100Mhz);
      n++;
    end while (!tick_out && n < 30);
    check("tick_seen", {31'b0, tick_out}, 32'd1);
  endtask

  // Returns on the first unblanked cycle of a digit-0 slot.
  task automatic align_slot0();
    logic [3:0] prev;
    int n;
    n = 0;
    do begin
      prev = anode;
      @(negedge clock_100Mhz);
      n++;
    end while (!(prev == 4'b1111 && anode == 4'b1110) && n < 64);
    check("align_slot0", {28'b0, anode}, 32'h0000000E);
  endtask

  logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_seg [4] = '{7'b0010010, 7'b1001100, 7'b1111111, 7'b1111111};
  logic       exp_dp  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    int first_tick;
    int phase;
    int slot;
    logic [11:0] exp_disp;

    repeat (3) @(negedge clock_100Mhz);
    check("rst_anode", {28'b0, anode}, 32'hF);
    check("rst_seg", {25'b0, seg}, 32'h7F);
    check("rst_dp", {31'b0, dp}, 32'h1);
    check("rst_count", {16'b0, count_value}, 32'h0);
    check("rst_tick_out", {31'b0, tick_out}, 32'h0);

    // First tick 10 cycles after release; first slot is digit 0 starting blanked.
    reset = 1'b0;
    first_tick = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock_100Mhz);
      if (i == 1) check("start_blank", {28'b0, anode}, 32'hF);
      if (i == 3) check("start_digit0", {28'b0, anode}, 32'hE);
      if (tick_out && first_tick == 0) first_tick = i;
    end
    check("first_tick_delay", first_tick, 32'd10);

    // Decimal up with ripple carry.
    en = 1'b1; up_down = 1'b1; hex_mode = 1'b0;
    do_load(16'h0998);
    wait_tick(n);
    check("dec_up_0999", {16'b0, count_value}, 32'h0999);
    wait_tick(n);
    check("dec_up_1000", {16'b0, count_value}, 32'h1000);
    check("tick_period", n, 32'd10);

    // Wraps in hex and decimal.
    hex_mode = 1'b1;
    do_load(16'hFFFF);
    wait_tick(n);
    check("hex_up_wrap", {16'b0, count_value}, 32'h0000);
    up_down = 1'b0;
    wait_tick(n);
    check("hex_down_wrap", {16'b0, count_value}, 32'hFFFF);
    hex_mode = 1'b0;
    @(negedge clock_100Mhz);
    check("mode_keeps_digits", {16'b0, count_value}, 32'hFFFF);
    do_load(16'h0000);
    wait_tick(n);
    check("dec_down_wrap", {16'b0, count_value}, 32'h9999);
    hex_mode = 1'b1;
    do_load(16'h00A0);
    hex_mode = 1'b0;
    wait_tick(n);
    check("dec_down_from_A", {16'b0, count_value}, 32'h0099);

    // Load coincident with a tick wins and is clamped.
    up_down = 1'b1;
    wait_tick(n);
    repeat (9) @(negedge clock_100Mhz);
    load = 1'b1; load_value = 16'hA3C1;
    @(negedge clock_100Mhz);
    load = 1'b0;
    check("load_clamp", {16'b0, count_value}, 32'h9391);
    check("load_on_tick", {31'b0, tick_out}, 32'h1);
    wait_tick(n);
    check("after_load_step", {16'b0, count_value}, 32'h9392);

    // Scan pattern over four slots.
    en = 1'b0;
    do_load(16'h0042);
    blank_lz = 1'b1; dp_in = 4'b0010;
    align_slot0();
    for (int c = 0; c < 32; c++) begin
      phase = (c + 2) % 8;
      slot  = ((c + 2) / 8) % 4;
      exp_disp = (phase < 2) ? 12'hFFF : {exp_an[slot], exp_seg[slot], exp_dp[slot]};
      check($sformatf("scan_c%0d", c), {20'b0, anode, seg, dp}, {20'b0, exp_disp});
      @(negedge clock_100Mhz);
    end

    // Decimal error glyph versus hex glyph for an out-of-range digit.
    blank_lz = 1'b0; dp_in = 4'b0000; hex_mode = 1'b1;
    do_load(16'h000B);
    hex_mode = 1'b0;
    align_slot0();
    check("dec_err_glyph", {25'b0, seg}, 32'h7E);
    hex_mode = 1'b1;
    @(negedge clock_100Mhz);
    check("hex_b_glyph", {25'b0, seg}, 32'h60);

    // Asynchronous reset during slot 2.
    hex_mode = 1'b0;
    do_load(16'h0057);
    align_slot0();
    repeat (16) @(negedge clock_100Mhz);
    check("pre_rst_slot2", {28'b0, anode}, 32'hB);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_disp", {20'b0, anode, seg, dp}, 32'hFFF);
    check("mid_rst_count", {16'b0, count_value}, 32'h0);
    check("mid_rst_tick_out", {31'b0, tick_out}, 32'h0);
    @(negedge clock_100Mhz);
    reset = 1'b0;
    @(negedge clock_100Mhz);
    check("restart_blank", {28'b0, anode}, 32'hF);
    repeat (2) @(negedge clock_100Mhz);
    check("restart_digit0", {28'b0, anode}, 32'hE);
    check("restart_count", {16'b0, count_value}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
